// File: rtl/pool_stream_mc.sv
// Multi-channel streaming N x N pooling stage (max or average) with a ready/valid
// result register and a frame_done pulse on delivery of the last window of a frame.
module pool_stream_mc #(
    parameter int BitSize    = 4,
    parameter int Channels   = 2,
    parameter int ImageWidth = 8,
    parameter int N          = 2
) (
    input  logic                         clk,
    input  logic                         res_n,
    input  logic                         in_valid,
    input  logic [Channels*BitSize-1:0]  in_data,
    input  logic                         mode,
    output logic                         out_ready,
    input  logic                         next_ready,
    output logic                         out_valid,
    output logic [Channels*BitSize-1:0]  out_data,
    output logic                         frame_done
);

    localparam int LogN = $clog2(N);
    localparam int AccW = BitSize + 2 * LogN;
    localparam int Cols = ImageWidth / N;
    localparam int CW   = (ImageWidth > 1) ? $clog2(ImageWidth) : 1;
    localparam int IW   = (Cols > 1) ? $clog2(Cols) : 1;
    localparam logic [CW-1:0] LastPos = CW'(ImageWidth - 1);

    logic [CW-1:0]           row_q;
    logic [CW-1:0]           col_q;
    logic                    mode_q;
    logic                    out_last_q;
    logic signed [AccW-1:0]  part_q   [Cols][Channels];
    logic signed [AccW-1:0]  pix_ext  [Channels];
    logic signed [AccW-1:0]  next_acc [Channels];
    logic signed [AccW-1:0]  avg_acc  [Channels];
    logic [Channels*BitSize-1:0] result;

    logic          accept;
    logic          first_px;
    logic          win_open;
    logic          win_close;
    logic          frame_end;
    logic          mode_eff;
    logic [IW-1:0] col_idx;

    assign out_ready  = !out_valid || next_ready;
    assign accept     = in_valid && out_ready;
    assign first_px   = (row_q == '0) && (col_q == '0);
    assign win_open   = (row_q[LogN-1:0] == '0) && (col_q[LogN-1:0] == '0);
    assign win_close  = (&row_q[LogN-1:0]) && (&col_q[LogN-1:0]);
    assign frame_end  = (row_q == LastPos) && (col_q == LastPos);
    assign col_idx    = IW'(col_q >> LogN);
    // Pixel (0,0) already pools with the live mode input, so the whole frame is consistent.
    assign mode_eff   = first_px ? mode : mode_q;
    assign frame_done = out_valid && next_ready && out_last_q;

    always_comb begin
        result   = '0;
        pix_ext  = '{default: '0};
        next_acc = '{default: '0};
        avg_acc  = '{default: '0};
        for (int k = 0; k < Channels; k++) begin
            pix_ext[k] = AccW'($signed(in_data[k*BitSize +: BitSize]));
            if (win_open)
                next_acc[k] = pix_ext[k];
            else if (mode_eff)
                next_acc[k] = part_q[col_idx][k] + pix_ext[k];
            else
                next_acc[k] = (pix_ext[k] > part_q[col_idx][k]) ? pix_ext[k] : part_q[col_idx][k];
            avg_acc[k] = next_acc[k] >>> (2 * LogN);
            result[k*BitSize +: BitSize] = mode_eff ? avg_acc[k][BitSize-1:0]
                                                    : next_acc[k][BitSize-1:0];
        end
    end

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            row_q      <= '0;
            col_q      <= '0;
            mode_q     <= 1'b0;
            out_valid  <= 1'b0;
            out_last_q <= 1'b0;
            out_data   <= '0;
            for (int i = 0; i < Cols; i++)
                for (int k = 0; k < Channels; k++)
                    part_q[i][k] <= '0;
        end else begin
            if (accept) begin
                for (int k = 0; k < Channels; k++)
                    part_q[col_idx][k] <= next_acc[k];
                if (first_px)
                    mode_q <= mode;
                if (col_q == LastPos) begin
                    col_q <= '0;
                    row_q <= (row_q == LastPos) ? '0 : row_q + CW'(1);
                end else begin
                    col_q <= col_q + CW'(1);
                end
            end
            // A window closing while the old result drains replaces it without a bubble.
            if (accept && win_close) begin
                out_data   <= result;
                out_valid  <= 1'b1;
                out_last_q <= frame_end;
            end else if (next_ready) begin
                out_valid  <= 1'b0;
                out_last_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pool_stream_mc.sv
// Directed bench for pool_stream_mc: table-driven first-window vectors plus
// back-pressure, mid-frame reset and an N=4 / 3-lane continuous stream.
module tb_pool_stream_mc;

    typedef struct packed {
        logic        mf;
        logic        mr;
        logic [15:0] l0;
        logic [15:0] l1;
        logic [3:0]  e0;
        logic [3:0]  e1;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        res_n;
    logic        in_valid, mode, next_ready, out_ready, out_valid, frame_done;
    logic [7:0]  in_data, out_data;
    logic        in_valid4, mode4, next_ready4, out_ready4, out_valid4, frame_done4;
    logic [11:0] in_data4, out_data4;

    pool_stream_mc #(.BitSize(4), .Channels(2), .ImageWidth(8), .N(2)) dut (
        .clk(clk), .res_n(res_n), .in_valid(in_valid), .in_data(in_data), .mode(mode),
        .out_ready(out_ready), .next_ready(next_ready), .out_valid(out_valid),
        .out_data(out_data), .frame_done(frame_done)
    );

    pool_stream_mc #(.BitSize(4), .Channels(3), .ImageWidth(8), .N(4)) dut4 (
        .clk(clk), .res_n(res_n), .in_valid(in_valid4), .in_data(in_data4), .mode(mode4),
        .out_ready(out_ready4), .next_ready(next_ready4), .out_valid(out_valid4),
        .out_data(out_data4), .frame_done(frame_done4)
    );

    int checks   = 0;
    int failures = 0;
    int img [8][8][3];
    logic [11:0] got_q[$];
    logic [11:0] got4_q[$];
    int fd_count  = 0;
    int fd4_count = 0;
    vec_t vecs [6];

    // Results and frame_done pulses are collected half a cycle before the consuming edge.
    always @(negedge clk) begin
        if (out_valid === 1'b1 && next_ready === 1'b1) got_q.push_back({4'b0, out_data});
        if (frame_done === 1'b1) fd_count++;
        if (out_valid4 === 1'b1 && next_ready4 === 1'b1) got4_q.push_back(out_data4);
        if (frame_done4 === 1'b1) fd4_count++;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    function automatic int pixel(input int seed, input int r, input int c, input int l);
        return ((r * 7 + c * 3 + l * 5 + seed * 11) % 16) - 8;
    endfunction

    function automatic int sx4(input logic [3:0] v);
        return int'($signed(v));
    endfunction

    task automatic fill_image(input int seed);
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                for (int l = 0; l < 3; l++)
                    img[r][c][l] = pixel(seed, r, c, l);
    endtask

    function automatic logic [11:0] pack(input int r, input int c, input int lanes);
        logic [11:0] d;
        int v;
        d = '0;
        for (int l = 0; l < lanes; l++) begin
            v = img[r][c][l];
            d[l*4 +: 4] = v[3:0];
        end
        return d;
    endfunction

    // Reference pooling computed straight from the whole stored frame.
    function automatic logic [11:0] model(input int n, input int lanes, input logic m,
                                          input int wr, input int wc);
        logic [11:0] res;
        int acc, v, sh;
        res = '0;
        sh  = (n == 4) ? 4 : 2;
        for (int l = 0; l < lanes; l++) begin
            acc = m ? 0 : -100;
            for (int dr = 0; dr < n; dr++)
                for (int dc = 0; dc < n; dc++) begin
                    v = img[wr*n + dr][wc*n + dc][l];
                    if (m) acc += v;
                    else if (v > acc) acc = v;
                end
            if (m) acc = acc >>> sh;
            res[l*4 +: 4] = acc[3:0];
        end
        return res;
    endfunction

    task automatic applyStimulus(input logic [7:0] d, input logic m);
        bit ok;
        ok = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        mode     = m;
        for (int g = 0; g < 200; g++) begin
            @(negedge clk);
            if (out_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        if (ok) begin
            @(posedge clk);
            #1;
        end else begin
            checks++;
            failures++;
            $display("[TB] FAIL handshake_timeout: got out_ready=%b expected 1", out_ready);
        end
        in_valid = 1'b0;
    endtask

    task automatic run_frame(input logic mf, input logic mr, input bit check_latency,
                             input logic [7:0] exp_first);
        logic [11:0] px;
        for (int p = 0; p < 64; p++) begin
            px = pack(p / 8, p % 8, 2);
            applyStimulus(px[7:0], (p == 0) ? mf : mr);
            if (check_latency && p == 8) checkOutput("latency_before", out_valid, 1'b0);
            if (check_latency && p == 9) begin
                checkOutput("latency_valid", out_valid, 1'b1);
                checkOutput("latency_data", out_data, exp_first);
            end
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic check_frame(input string name, input logic m);
        checkOutput($sformatf("%s_count", name), got_q.size(), 16);
        for (int i = 0; i < 16; i++)
            if (i < got_q.size())
                checkOutput($sformatf("%s_win%0d", name, i), got_q[i], model(2, 2, m, i / 4, i % 4));
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        vecs[0] = '{mf: 1'b0, mr: 1'b0, l0: 16'hF827, l1: 16'h288F, e0: 4'h7, e1: 4'h2};
        vecs[1] = '{mf: 1'b1, mr: 1'b1, l0: 16'hF827, l1: 16'h288F, e0: 4'h0, e1: 4'hC};
        vecs[2] = '{mf: 1'b0, mr: 1'b1, l0: 16'h8888, l1: 16'hFFFF, e0: 4'h8, e1: 4'hF};
        vecs[3] = '{mf: 1'b1, mr: 1'b0, l0: 16'h7777, l1: 16'h9888, e0: 4'h7, e1: 4'h8};
        vecs[4] = '{mf: 1'b1, mr: 1'b1, l0: 16'h000F, l1: 16'h0111, e0: 4'hF, e1: 4'h0};
        vecs[5] = '{mf: 1'b0, mr: 1'b0, l0: 16'h9EBD, l1: 16'hC3F0, e0: 4'hE, e1: 4'h3};

        res_n = 1'b0;
        in_valid = 1'b1; in_data = 8'hA5; mode = 1'b1; next_ready = 1'b1;
        in_valid4 = 1'b0; in_data4 = '0; mode4 = 1'b0; next_ready4 = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("reset_out_valid", out_valid, 1'b0);
        checkOutput("reset_out_ready", out_ready, 1'b1);
        checkOutput("reset_frame_done", frame_done, 1'b0);
        checkOutput("reset_out_data", out_data, 8'h00);
        checkOutput("reset_out_valid4", out_valid4, 1'b0);
        in_valid = 1'b0;
        @(negedge clk);
        res_n = 1'b1;
        @(posedge clk);
        #1;

        // Table vectors: window (0,0) forced to the listed lane values.
        for (int i = 0; i < 6; i++) begin
            fill_image(i + 1);
            for (int q = 0; q < 4; q++) begin
                img[q / 2][q % 2][0] = sx4(vecs[i].l0[q*4 +: 4]);
                img[q / 2][q % 2][1] = sx4(vecs[i].l1[q*4 +: 4]);
            end
            got_q.delete();
            fd_count = 0;
            run_frame(vecs[i].mf, vecs[i].mr, (i == 0), {vecs[i].e1, vecs[i].e0});
            if (got_q.size() > 0)
                checkOutput($sformatf("vec%0d_first", i), got_q[0], {4'b0, vecs[i].e1, vecs[i].e0});
            else
                checkOutput($sformatf("vec%0d_first_present", i), got_q.size(), 1);
            check_frame($sformatf("vec%0d", i), vecs[i].mf);
            checkOutput($sformatf("vec%0d_frame_done", i), fd_count, 1);
        end

        // Back-pressure at the first result of a max frame.
        fill_image(20);
        got_q.delete();
        fd_count = 0;
        fork
            begin
                logic [11:0] px;
                for (int p = 0; p < 64; p++) begin
                    px = pack(p / 8, p % 8, 2);
                    applyStimulus(px[7:0], 1'b0);
                end
            end
            begin
                logic [7:0]  held;
                logic [11:0] first_exp;
                bit seen;
                seen = 1'b0;
                for (int g = 0; g < 200 && !seen; g++) begin
                    @(posedge clk);
                    #1;
                    if (out_valid === 1'b1) seen = 1'b1;
                end
                checkOutput("bp_first_seen", seen, 1'b1);
                next_ready = 1'b0;
                held = out_data;
                first_exp = model(2, 2, 1'b0, 0, 0);
                checkOutput("bp_value", held, first_exp[7:0]);
                repeat (5) begin
                    @(negedge clk);
                    checkOutput("bp_out_ready", out_ready, 1'b0);
                    checkOutput("bp_out_valid", out_valid, 1'b1);
                    checkOutput("bp_hold", out_data, held);
                end
                @(posedge clk);
                #1;
                next_ready = 1'b1;
            end
        join
        repeat (3) @(posedge clk);
        #1;
        check_frame("bp", 1'b0);
        checkOutput("bp_frame_done", fd_count, 1);

        // Reset after 37 pixels, then a fresh full frame.
        fill_image(30);
        got_q.delete();
        fd_count = 0;
        for (int p = 0; p < 37; p++) begin
            logic [11:0] px;
            px = pack(p / 8, p % 8, 2);
            applyStimulus(px[7:0], 1'b1);
        end
        @(negedge clk);
        res_n = 1'b0;
        #1;
        checkOutput("midreset_out_valid", out_valid, 1'b0);
        checkOutput("midreset_out_ready", out_ready, 1'b1);
        checkOutput("midreset_out_data", out_data, 8'h00);
        checkOutput("midreset_no_frame_done", fd_count, 0);
        in_valid = 1'b1;
        in_data  = 8'h3C;
        repeat (2) @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        res_n = 1'b1;
        @(posedge clk);
        #1;
        fill_image(31);
        got_q.delete();
        fd_count = 0;
        run_frame(1'b0, 1'b0, 1'b0, 8'h00);
        check_frame("postreset", 1'b0);
        checkOutput("postreset_frame_done", fd_count, 1);

        // N=4, 3 lanes: two back-to-back frames, average then max.
        fill_image(40);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                for (int l = 0; l < 3; l++)
                    img[r][c][l] = -8;
        got4_q.delete();
        fd4_count = 0;
        for (int f = 0; f < 2; f++)
            for (int p = 0; p < 64; p++) begin
                in_valid4 = 1'b1;
                in_data4  = pack(p / 8, p % 8, 3);
                mode4     = (p == 0) ? (f == 0) : (f != 0);
                @(negedge clk);
                if (out_ready4 !== 1'b1) checkOutput("n4_out_ready", out_ready4, 1'b1);
                @(posedge clk);
                #1;
            end
        in_valid4 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("n4_count", got4_q.size(), 8);
        if (got4_q.size() > 0) checkOutput("n4_all_neg8_avg", got4_q[0], 12'h888);
        for (int i = 0; i < 8; i++)
            if (i < got4_q.size())
                checkOutput($sformatf("n4_win%0d", i), got4_q[i],
                            model(4, 3, (i < 4), (i % 4) / 2, i % 2));
        checkOutput("n4_frame_done", fd4_count, 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pool_stream_mc.md
# pool_stream_mc

Multi-channel streaming pooling stage for the conv/pooling pipeline. Accepts one raster-order pixel per handshake, carrying `Channels` parallel signed lanes from a convolution layer. Reduces each non-overlapping `N`×`N` window to one result per lane, using either max or average. It generalises the fixed 2×2 max pooling inside the conv/pooling top with a configurable window size, lane count, run-time mode and output back-pressure.

## Interface
- `BitSize`, 4, width of one signed two's-complement lane
- `Channels`, 2, number of parallel lanes (kernels) per pixel
- `ImageWidth`, 8, square input frame edge in pixels; multiple of `N`
- `N`, 2, pooling window edge = stride; power of two, ≥2
- `clk`  in  1  single clock, rising edge
- `res_n`  in  1  reset; asynchronous, active-low
- `in_valid`  in  1  input pixel present
- `in_data`  in  `Channels`×`BitSize`  input lanes, lane k at bits [k*BitSize +: BitSize]
- `mode`  in  1  0 = max, 1 = average; sampled on the first pixel of each frame
- `out_ready`  out  1  block can accept a pixel this cycle
- `next_ready`  in  1  downstream accepts the result this cycle
- `out_valid`  out  1  result register holds an undelivered result
- `out_data`  out  `Channels`×`BitSize`  pooled lanes, same packing as `in_data`
- `frame_done`  out  1  one-cycle pulse when the last result of a frame is delivered

## Operation
- A pixel is accepted when `in_valid && out_ready` at a rising `clk` edge.
- `out_ready = !out_valid || next_ready`, which is combinational.
- Column counter `col` runs 0..ImageWidth-1 and row counter `row` runs 0..ImageWidth-1. Both advance per accepted pixel. `col` wraps to 0 and increments `row`. After (ImageWidth-1, ImageWidth-1) both wrap to 0 and the next frame starts.
- Partial buffer: `ImageWidth/N` entries × `Channels` accumulators, indexed by `col/N`.
- Accumulator width: `BitSize + 2*log2(N)` bits, signed.
- Pixel with `row%N==0 && col%N==0`: the entry is loaded with the sign-extended pixel.
- Any other pixel updates the entry:
  - in max mode, to the signed maximum of entry and pixel;
  - in average mode, to the sum of entry and pixel.
- Pixel with `row%N==N-1 && col%N==N-1` closes the window:
  - max mode: the result is the combined value, truncated to `BitSize` (exact).
  - average mode: the result is the sum arithmetically right-shifted by `2*log2(N)`. This is floor toward −∞, and always fits in `BitSize`.
  - The result is written to `out_data` and `out_valid` is set.
- The frame mode register is loaded from `mode` only when pixel (0,0) is accepted. Changes to `mode` mid-frame have no effect until the next frame.
- Delivery: when `out_valid && next_ready`, the result is consumed.
  - If a new window closes in the same cycle, `out_data` takes the new result and `out_valid` stays 1.
  - Otherwise `out_valid` clears.
- `frame_done` pulses in the cycle the result of the window at (row/N, col/N) = (ImageWidth/N-1, ImageWidth/N-1) is consumed.
- Results per frame: (ImageWidth/N)², in row-major window order.

## Timing
- Reset (`res_n` low, asynchronous):
  - `row`, `col`, the partial buffer, the mode register (max) and `out_data` clear to 0.
  - `out_valid` = 0 and `frame_done` = 0.
  - `out_ready` reads 1, but `in_valid` is ignored while `res_n` is low.
- Latency: the result is visible on `out_data`/`out_valid` in the cycle after the window-closing pixel is accepted.
- Back-pressure:
  - While `out_valid && !next_ready`, `out_ready` = 0. No pixel is accepted and `out_data` holds stable.
  - The partial buffer is untouched during back-pressure.
- Throughput: one pixel per cycle with `next_ready` held at 1. There are no bubbles across row or frame boundaries.
- Reset mid-frame: the partial frame is discarded and the next accepted pixel is (0,0) of a new frame. Any pending result is dropped and no `frame_done` is generated.
- Gaps in `in_valid` only stall the counters. No timeout applies.

## Test plan
- Max mode, `Channels`=2, `BitSize`=4, `ImageWidth`=8, `N`=2. First window, lane 0 = 7, 2, −8, −1 (rows 0/1, cols 0/1) → lane 0 result 7, one cycle after the 10th accepted pixel, 16 results per frame.
- Average mode, same window, lane 0 sum 0 → result 0. Lane 1 = −1, −8, −8, 2 → sum −15 → result −4 (0b1100).
- Back-pressure: hold `next_ready`=0 at the first result → `out_ready`=0. `in_data` pixels are not consumed and `out_data` is stable. Release → pixel stream resumes at the same `col`, with no lost or duplicated result.
- `mode` toggled mid-frame → the entire frame uses the mode sampled at (0,0). The next frame uses the new mode.
- Reset asserted after 37 pixels → `out_valid`=0 immediately. A fresh frame of 64 pixels yields exactly 16 correct results and one `frame_done`.
- `N`=4, `Channels`=3, `ImageWidth`=8, continuous stream of two frames with `next_ready`=1 → 4 results per frame. `frame_done` pulses twice, and the all-−8 window averages to −8.
